// File: rtl/cpu_write_capture.sv
// ---------------------------------------------------------------------------
// cpu_write_capture
//
// Front end for the mapper bank registers. The asynchronous NES CPU bus is
// oversampled with the fast system clock. Each genuine CPU write to
// $8000-$FFFF becomes one clean single-clock transaction {address, data}. The
// transaction is queued in a 2-entry FIFO and handed out over a valid/ready
// interface. Mapper register logic consumes these transactions instead of
// clocking on romsel edges.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth on m2/romsel/cpu_rw_in (2..4)
//   SETTLE_CYCLES clk cycles after the synced m2 rise before the address and
//                 data buses are sampled (1..15)
//
// Ports:
//   clk          in   system clock (at least 8x the m2 frequency)
//   rst          in   synchronous, active-high reset
//   m2           in   CPU phi2, asynchronous
//   romsel       in   CPU /ROMSEL, active low, asynchronous
//   cpu_rw_in    in   CPU R/W, 0 = write
//   cpu_addr_in  in   CPU A14..A0, sampled only at the capture point
//   cpu_data_in  in   CPU data bus, sampled only at the capture point
//   rom_data     in   PRG flash output (only with BUS_CONFLICT_EN)
//   wr_valid     out  FIFO head holds a captured write
//   wr_ready     in   consumer accepts the head this cycle
//   wr_addr      out  captured A14..A0 at the FIFO head
//   wr_data      out  captured data at the FIFO head
//   overflow     out  sticky: a write was dropped because the FIFO was full
//
// Optional feature macro: BUS_CONFLICT_EN
//   When defined, the rom_data port is added. The captured data is then
//   cpu_data_in & rom_data, which emulates discrete-logic bus conflicts.
//   When undefined, the captured data is cpu_data_in unmodified.
// ---------------------------------------------------------------------------
module cpu_write_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m2,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
`ifdef BUS_CONFLICT_EN
  input  logic [7:0]  rom_data,
`endif
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] m2_sync;
  logic [SYNC_STAGES-1:0] romsel_sync;
  logic [SYNC_STAGES-1:0] rw_sync;
  logic [SYNC_STAGES-1:0] vld_sync;

  logic m2_s;
  logic romsel_s;
  logic rw_s;
  logic m2_prev;
  logic armed;
  logic m2_rise;
  logic m2_fall;

  state_t state;
  state_t next_state;
  logic [3:0] cnt;
  logic [3:0] next_cnt;
  logic capture;

  logic [7:0]  cap_data;
  logic [22:0] fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        pop;
  logic        push_ok;
  logic        drop;

  // vld_sync shifts in ones alongside the bus synchronizers. When its top bit
  // is set, every synchronizer stage holds a real sample rather than a reset
  // value.
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_sync     <= '0;
      romsel_sync <= '0;
      rw_sync     <= '0;
      vld_sync    <= '0;
    end else begin
      m2_sync     <= {m2_sync[SYNC_STAGES-2:0], m2};
      romsel_sync <= {romsel_sync[SYNC_STAGES-2:0], romsel};
      rw_sync     <= {rw_sync[SYNC_STAGES-2:0], cpu_rw_in};
      vld_sync    <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign m2_s     = m2_sync[SYNC_STAGES-1];
  assign romsel_s = romsel_sync[SYNC_STAGES-1];
  assign rw_s     = rw_sync[SYNC_STAGES-1];

  // After reset the synchronizer refills from 0. If m2 was already high,
  // this would look like a rise. Rise detection is therefore armed only after
  // a genuine low m2 has been seen, so a partial m2 phase is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_prev <= 1'b0;
      armed   <= 1'b0;
    end else begin
      m2_prev <= m2_s;
      if (vld_sync[SYNC_STAGES-1] && !m2_s)
        armed <= 1'b1;
    end
  end

  assign m2_rise = armed & m2_s & ~m2_prev;
  assign m2_fall = ~m2_s & m2_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // A runt m2 pulse (m2 drops during SETTLE) aborts without capturing.
  // HOLD ensures at most one capture per m2 high phase.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (m2_rise) begin
          next_cnt   = SETTLE_LOAD;
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (!m2_s) begin
          next_state = IDLE;
        end else if (cnt != 4'd0) begin
          next_cnt = cnt - 4'd1;
        end else begin
          capture    = ~romsel_s & ~rw_s;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (m2_fall)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef BUS_CONFLICT_EN
  assign cap_data = cpu_data_in & rom_data;
`else
  assign cap_data = cpu_data_in;
`endif

  // When the FIFO is full and a pop occurs, wr_ptr equals rd_ptr. The new
  // entry lands in the slot being vacated by the pop.
  assign pop     = wr_valid & wr_ready;
  assign push_ok = capture & ((count != 2'd2) | pop);
  assign drop    = capture & (count == 2'd2) & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      overflow    <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= {cpu_addr_in, cap_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
    end
  end

  assign wr_valid          = (count != 2'd0);
  assign {wr_addr, wr_data} = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_cpu_write_capture.sv
// ---------------------------------------------------------------------------
// tb_cpu_write_capture
//
// Directed bench for cpu_write_capture. Each CPU bus cycle that should be
// captured pushes its expected {addr, data} onto a scoreboard queue. A monitor
// pops the queue on every wr_valid/wr_ready handshake and compares. An
// unexpected handshake counts as a miscompare. Build with +define+
// BUS_CONFLICT_EN to exercise the bus-conflict variant.
// ---------------------------------------------------------------------------
module tb_cpu_write_capture;

  localparam int SYNC_STAGES   = 2;
  localparam int SETTLE_CYCLES = 4;
  localparam int LAT           = SYNC_STAGES + SETTLE_CYCLES + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        m2;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic [7:0]  rom_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        overflow;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [22:0] exp_q[$];

  cpu_write_capture #(
    .SYNC_STAGES  (SYNC_STAGES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m2         (m2),
    .romsel     (romsel),
    .cpu_rw_in  (cpu_rw_in),
    .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in),
`ifdef BUS_CONFLICT_EN
    .rom_data   (rom_data),
`endif
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every accepted head must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && wr_valid === 1'b1 && wr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_write", 32'({wr_addr, wr_data}), 32'hFFFF_FFFF);
      end else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        check_output("wr_addr", 32'(wr_addr), 32'(e[22:8]));
        check_output("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
  end

  // One CPU bus cycle. romsel follows A15 while m2 is high, as on the real bus.
  task automatic apply_stimulus(input logic [15:0] addr, input logic [7:0] data,
                                input logic rw, input int high_clks,
                                input bit expect_push, input bit chk_lat);
    logic [7:0] ed;
    ed = data;
`ifdef BUS_CONFLICT_EN
    ed = data & rom_data;
`endif
    if (expect_push)
      exp_q.push_back({addr[14:0], ed});
    @(negedge clk);
    cpu_addr_in = addr[14:0];
    cpu_data_in = data;
    cpu_rw_in   = rw;
    romsel      = 1'b1;
    m2          = 1'b0;
    repeat (3) @(negedge clk);
    m2     = 1'b1;
    romsel = ~addr[15];
    for (int i = 1; i <= high_clks; i++) begin
      @(negedge clk);
      if (chk_lat && i == LAT - 1)
        check_output("latency_early", 32'(wr_valid), 32'd0);
      if (chk_lat && i == LAT)
        check_output("latency_valid", 32'(wr_valid), 32'd1);
    end
    m2     = 1'b0;
    romsel = 1'b1;
    repeat (4) @(negedge clk);
    cpu_rw_in = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && wr_valid === 1'b0)
        break;
      @(negedge clk);
    end
    check_output("drain_pending", 32'(exp_q.size()), 32'd0);
    check_output("drain_valid", 32'(wr_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst         = 1'b1;
    m2          = 1'b0;
    romsel      = 1'b1;
    cpu_rw_in   = 1'b1;
    cpu_addr_in = '0;
    cpu_data_in = '0;
    rom_data    = 8'hFF;
    wr_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_wr_valid", 32'(wr_valid), 32'd0);
    check_output("reset_wr_addr", 32'(wr_addr), 32'd0);
    check_output("reset_wr_data", 32'(wr_data), 32'd0);
    check_output("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    $display("[TB] single write $8000<=02");
    wr_ready = 1'b1;
    apply_stimulus(16'h8000, 8'h02, 1'b0, 12, 1'b1, 1'b1);
    wait_drain();
    check_output("single_overflow", 32'(overflow), 32'd0);

    $display("[TB] read $C000 and write $6000 ignored");
    apply_stimulus(16'hC000, 8'h5A, 1'b1, 12, 1'b0, 1'b0);
    check_output("read_ignored", 32'(wr_valid), 32'd0);
    apply_stimulus(16'h6000, 8'h33, 1'b0, 12, 1'b0, 1'b0);
    check_output("low_write_ignored", 32'(wr_valid), 32'd0);

    $display("[TB] runt m2 pulse");
    apply_stimulus(16'h8000, 8'h77, 1'b0, 2, 1'b0, 1'b0);
    check_output("runt_ignored", 32'(wr_valid), 32'd0);

    $display("[TB] FIFO fill and overflow");
    wr_ready = 1'b0;
    apply_stimulus(16'h8000, 8'h01, 1'b0, 12, 1'b1, 1'b0);
    apply_stimulus(16'h9000, 8'h02, 1'b0, 12, 1'b1, 1'b0);
    apply_stimulus(16'hA000, 8'h03, 1'b0, 12, 1'b0, 1'b0);
    check_output("full_valid", 32'(wr_valid), 32'd1);
    check_output("full_head_addr", 32'(wr_addr), 32'h0000);
    check_output("full_head_data", 32'(wr_data), 32'h01);
    check_output("full_overflow", 32'(overflow), 32'd1);
    wr_ready = 1'b1;
    wait_drain();
    check_output("overflow_sticky", 32'(overflow), 32'd1);

    $display("[TB] reset during SETTLE");
    @(negedge clk);
    cpu_addr_in = 15'h7FFF;
    cpu_data_in = 8'h55;
    cpu_rw_in   = 1'b0;
    m2          = 1'b1;
    romsel      = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("midrst_overflow", 32'(overflow), 32'd0);
    check_output("midrst_valid", 32'(wr_valid), 32'd0);
    repeat (12) @(negedge clk);
    check_output("midrst_no_capture", 32'(wr_valid), 32'd0);
    m2     = 1'b0;
    romsel = 1'b1;
    repeat (4) @(negedge clk);
    cpu_rw_in = 1'b1;
    apply_stimulus(16'h8000, 8'hAA, 1'b0, 12, 1'b1, 1'b0);
    wait_drain();

`ifdef BUS_CONFLICT_EN
    $display("[TB] bus conflict write");
    rom_data = 8'h01;
    apply_stimulus(16'h8000, 8'h03, 1'b0, 12, 1'b1, 1'b0);
    wait_drain();
    rom_data = 8'hFF;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_write_capture.md
Name: cpu_write_capture

Overview:
- Front-end stage directly upstream of the mapper bank registers.
- Oversamples the asynchronous NES CPU bus (m2, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in) with a fast system clock.
- Detects genuine CPU writes to $8000-$FFFF and emits each one as a clean single-clock write transaction (address, data) over a valid/ready interface.
- Mapper register logic (bank latches, mirroring bits) consumes these transactions instead of clocking on romsel edges.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on m2, romsel and cpu_rw_in. Legal range 2-4.
- SETTLE_CYCLES, 4: clk cycles after the synced m2 rise before address and data are sampled. Legal range 1-15.

Ports:
- clk  in  1  system clock; at least 8x the m2 frequency.
- rst  in  1  synchronous, active-high reset.
- m2  in  1  CPU phi2, asynchronous.
- romsel  in  1  CPU /ROMSEL, active low, asynchronous.
- cpu_rw_in  in  1  CPU R/W; 0 = write.
- cpu_addr_in  in  15  CPU A14..A0.
- cpu_data_in  in  8  CPU data bus.
- wr_valid  out  1  FIFO head holds a captured write.
- wr_ready  in  1  consumer accepts the head this cycle.
- wr_addr  out  15  captured A14..A0 at the FIFO head.
- wr_data  out  8  captured data at the FIFO head.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Synchronizers: m2, romsel and cpu_rw_in each pass through SYNC_STAGES flops, giving m2_s, romsel_s and rw_s. Reset clears all synchronizer flops to 0. cpu_addr_in and cpu_data_in are sampled unsynchronized, only at the capture point.
- Edge detection: m2_rise is m2_s=1 with its previous value 0. m2_fall is the reverse.
- FSM states: IDLE, SETTLE, HOLD. Reset state is IDLE.
  - IDLE: on m2_rise, load cnt with SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: if m2_s=0, abort (runt pulse), go to IDLE, no capture. Otherwise, while cnt>0, decrement cnt. When cnt=0, evaluate the capture condition and go to HOLD.
  - Capture condition: romsel_s=0 and rw_s=0. If true, push {cpu_addr_in, cpu_data_in} this cycle. If false, nothing is pushed.
  - HOLD: stay until m2_fall, then go to IDLE. At most one capture per m2 high phase.
- FIFO: 2 entries, first-in first-out. The head drives wr_addr and wr_data. wr_valid is 1 when count is nonzero.
  - pop = wr_valid & wr_ready.
  - A push is accepted when count<2, or when count=2 and a pop occurs in the same cycle.
  - Simultaneous push and pop with count=1 leaves count at 1; the head becomes the new entry.
  - A push with count=2 and no pop is dropped and sets overflow. overflow clears only on rst.
- Latency: with the FIFO empty, wr_valid rises on the clk cycle after the capture cycle. With wr_ready held high, the entry drains one cycle after that.
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, overflow=0, FIFO empty, cnt=0.
- Reset mid-operation: a capture cycle coinciding with rst is discarded. The FSM returns to IDLE even if m2_s is high, and rearms only on the next m2_rise, so a partial cycle is never captured.
- Writes to $4020-$7FFF (romsel_s=1) and all reads are ignored.

Optional Feature:
- Macro: BUS_CONFLICT_EN.
- Defined:
  - Adds input port rom_data (8 bits), the PRG flash output during the same cycle.
  - The captured data is cpu_data_in & rom_data, emulating discrete-logic bus conflicts as on original boards.
- Undefined:
  - Port rom_data is absent.
  - The captured data is cpu_data_in unmodified.

Test Plan:
- Write $8000<=0x02 with m2 high for 12 clks, wr_ready=1 -> exactly one wr_valid pulse with wr_addr=0x0000, wr_data=0x02; overflow=0.
- Read at $C000 (rw=1), then write at $6000 (romsel high) -> wr_valid stays 0 throughout.
- m2 high pulse of 2 clks with SETTLE_CYCLES=4 during a write to $8000 -> no capture; the FSM returns to IDLE.
- wr_ready=0; three writes: $8000<=0x01, $9000<=0x02, $A000<=0x03 -> FIFO holds 0x01 then 0x02; overflow=1. Raising wr_ready drains 0x01 then 0x02, then wr_valid=0.
- Assert rst during SETTLE of a write $FFFF<=0x55 while m2 stays high -> no output; the next full write $8000<=0xAA is captured normally.
- With BUS_CONFLICT_EN: write 0x03 while rom_data=0x01 -> wr_data=0x01.
